conf_int_sub_iter_arch_agnos: RTL

Configurable-precision, iterative unsigned integer subtractor with valid/ready handshakes on input and output. It computes d = a − b, processing CHUNK_WIDTH bits per cycle with a rippled borrow. It is the subtracting counterpart of the existing adder operators and uses the same OP_BITWIDTH/DATA_PATH_BITWIDTH precision convention. The block sits in the approximate-operator library as a registered, area-lean alternative to a single-cycle subtractor.

---
 rtl/conf_int_sub_iter_arch_agnos.sv | 111 +++++++++++
 1 files changed

// File: rtl/conf_int_sub_iter_arch_agnos.sv
// rtl/conf_int_sub_iter_arch_agnos.sv - iterative chunked unsigned subtractor with masked precision and valid/ready handshakes
module conf_int_sub_iter_arch_agnos #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int CHUNK_WIDTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          borrow_out
);

    localparam int NUM_CHUNKS = DATA_PATH_BITWIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LOW_BITS   = DATA_PATH_BITWIDTH - OP_BITWIDTH;

    // Only the OP_BITWIDTH most significant bits of each operand take part.
    localparam logic [DATA_PATH_BITWIDTH-1:0] KEEP_MASK = {DATA_PATH_BITWIDTH{1'b1}} << LOW_BITS;
    localparam logic [IDX_W-1:0]              LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_bad_op_width
            $error("OP_BITWIDTH must not exceed DATA_PATH_BITWIDTH");
        end
        if ((DATA_PATH_BITWIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk_width
            $error("DATA_PATH_BITWIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state;
    logic [DATA_PATH_BITWIDTH-1:0]   a_q;
    logic [DATA_PATH_BITWIDTH-1:0]   b_q;
    logic [IDX_W-1:0]                idx;
    logic                            borrow;

    logic [CHUNK_WIDTH-1:0]          a_chunk;
    logic [CHUNK_WIDTH-1:0]          b_chunk;
    logic [CHUNK_WIDTH-1:0]          diff;
    logic                            borrow_next;

    // Operands are only taken while idle; there is no skid or bypass path.
    assign in_ready = (state == IDLE);

    // One chunk of the subtraction per cycle; the extra top bit of the widened difference is the borrow.
    always_comb begin
        a_chunk     = a_q[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk     = b_q[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
        {borrow_next, diff} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_WIDTH{1'b0}}, borrow};
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            borrow     <= 1'b0;
            d          <= '0;
            borrow_out <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a & KEEP_MASK;
                        b_q    <= b & KEEP_MASK;
                        idx    <= '0;
                        borrow <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // d is overwritten in place, so it only means something once out_valid is up.
                    d[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH] <= diff;
                    borrow <= borrow_next;
                    if (idx == LAST_IDX) begin
                        borrow_out <= borrow_next;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
